// File: rtl/fft_input_loader_if.sv
// fft_input_loader_if: sample stream (in_data/in_valid/in_sof/in_ready) and frame output (frame_out/frame_valid/frame_ack/frame_drop)
interface fft_input_loader_if #(parameter int D_WIDTH = 64);
  logic [15:0] in_data;
  logic in_valid, in_sof, in_ready;
  logic [16*D_WIDTH-1:0] frame_out;
  logic frame_valid, frame_ack, frame_drop;
  modport master(output in_data, in_valid, in_sof, frame_ack, input in_ready, frame_out, frame_valid, frame_drop);
  modport slave(input in_data, in_valid, in_sof, frame_ack, output in_ready, frame_out, frame_valid, frame_drop);
endinterface

// File: rtl/fft_input_loader.sv
// fft_input_loader: bit-reversed double-buffered frame loader; ports clk, rst (sync active-low), bus (slave: sample stream in, parallel frame out)
module fft_input_loader #(
  parameter int D_WIDTH = 64,
  parameter int LOG_2_WIDTH = 6
) (
  input logic clk,
  input logic rst,
  fft_input_loader_if.slave bus
);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state;
  logic [LOG_2_WIDTH-1:0] cnt, n, rev;
  logic [16*D_WIDTH-1:0] fill, fill_nx;
  logic accept, xfer, last;
  assign bus.in_ready = rst & (state == FILL);
  assign accept = bus.in_valid & bus.in_ready;
  assign xfer = bus.frame_valid & bus.frame_ack;
  assign n = bus.in_sof ? '0 : cnt;
  assign last = accept & (&n);
  always_comb begin
    rev = '0;
    for (int i = 0; i < LOG_2_WIDTH; i++) rev[i] = n[LOG_2_WIDTH-1-i];
  end
  always_comb begin
    fill_nx = fill;
    if (accept) fill_nx[16*rev +: 16] = bus.in_data;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FILL;
      cnt <= '0;
      bus.frame_out <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame_drop <= 1'b0;
    end else begin
      fill <= fill_nx;
      bus.frame_drop <= accept & bus.in_sof & (cnt != '0);
      if (accept) cnt <= n + 1'b1;
      if (state == HOLD) begin
        if (xfer) begin
          bus.frame_out <= fill;
          state <= FILL;
        end
      end else if (last) begin
        if (!bus.frame_valid || bus.frame_ack) begin
          bus.frame_out <= fill_nx;
          bus.frame_valid <= 1'b1;
        end else state <= HOLD;
      end else if (xfer) bus.frame_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader: directed checks of reset, ordering, backpressure, streaming, resync and mid-frame reset
module tb_fft_input_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  int drops = 0;
  int stalls = 0;
  int fv_bad = 0;
  int fv_hi = 0;
  fft_input_loader_if #(.D_WIDTH(64)) bus ();
  fft_input_loader #(.D_WIDTH(64), .LOG_2_WIDTH(6)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.frame_drop) drops++;
  function automatic logic [15:0] slot(input int j);
    return bus.frame_out[16*j +: 16];
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] d, input logic s);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_sof = s;
    if (!bus.in_ready) stalls++;
    tick();
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b1;
    bus.in_data = 16'h1234;
    bus.in_sof = 1'b0;
    bus.frame_ack = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    chk("rst_frame_out", 32'(bus.frame_out == '0), 32'd1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 64; i++) begin
      send(16'(i), i == 0);
      if (i == 62) chk("order_fv_early", 32'(bus.frame_valid), 32'd0);
    end
    chk("order_fv", 32'(bus.frame_valid), 32'd1);
    chk("order_slot0", 32'(slot(0)), 32'h0000);
    chk("order_slot32", 32'(slot(32)), 32'h0001);
    chk("order_slot16", 32'(slot(16)), 32'h0002);
    chk("order_slot48", 32'(slot(48)), 32'h0003);
    chk("order_slot40", 32'(slot(40)), 32'h0005);
    chk("order_slot63", 32'(slot(63)), 32'h003f);
    for (int i = 0; i < 64; i++) send(16'h8000 + 16'(i), i == 0);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_fv", 32'(bus.frame_valid), 32'd1);
    chk("bp_slot32_old", 32'(slot(32)), 32'h0001);
    bus.in_valid = 1'b1;
    bus.in_data = 16'hdead;
    for (int i = 0; i < 9; i++) tick();
    chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_slot32", 32'(slot(32)), 32'h0001);
    bus.in_valid = 1'b0;
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    chk("bp_slot32_new", 32'(slot(32)), 32'h8001);
    chk("bp_slot0_new", 32'(slot(0)), 32'h8000);
    chk("bp_fv_after", 32'(bus.frame_valid), 32'd1);
    chk("bp_ready_after", 32'(bus.in_ready), 32'd1);
    stalls = 0;
    bus.frame_ack = 1'b1;
    for (int i = 0; i < 192; i++) begin
      send(16'h1000 + 16'(i), i % 64 == 0);
      if (bus.frame_valid !== (i % 64 == 63)) fv_bad++;
      if (bus.frame_valid) fv_hi++;
    end
    chk("stream_stalls", 32'(stalls), 32'd0);
    chk("stream_fv_pos", 32'(fv_bad), 32'd0);
    chk("stream_fv_count", 32'(fv_hi), 32'd3);
    chk("stream_slot32", 32'(slot(32)), 32'h1081);
    tick();
    bus.frame_ack = 1'b0;
    chk("stream_fv_idle", 32'(bus.frame_valid), 32'd0);
    chk("stream_no_drop", 32'(drops), 32'd0);
    for (int k = 0; k < 20; k++) send(16'h2000 + 16'(k), k == 0);
    send(16'habcd, 1'b1);
    chk("resync_drop", 32'(bus.frame_drop), 32'd1);
    for (int m = 1; m < 64; m++) begin
      send(16'h3000 + 16'(m), 1'b0);
      if (m == 1) chk("resync_drop_clear", 32'(bus.frame_drop), 32'd0);
      if (m == 62) chk("resync_fv_early", 32'(bus.frame_valid), 32'd0);
    end
    chk("resync_fv", 32'(bus.frame_valid), 32'd1);
    chk("resync_drops", 32'(drops), 32'd1);
    chk("resync_slot0", 32'(slot(0)), 32'habcd);
    chk("resync_slot32", 32'(slot(32)), 32'h3001);
    chk("resync_slot63", 32'(slot(63)), 32'h303f);
    for (int k = 0; k < 30; k++) send(16'h5000 + 16'(k), k == 0);
    rst = 1'b0;
    tick();
    chk("mid_rst_fv", 32'(bus.frame_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    fv_hi = 0;
    for (int i = 0; i < 64; i++) begin
      send(16'h4000 + 16'(i), i == 0);
      if (bus.frame_valid) fv_hi++;
    end
    chk("mid_rst_frames", 32'(fv_hi), 32'd1);
    chk("mid_rst_fv_end", 32'(bus.frame_valid), 32'd1);
    chk("mid_rst_slot32", 32'(slot(32)), 32'h4001);
    chk("mid_rst_drops", 32'(drops), 32'd1);
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    chk("final_ack_fv", 32'(bus.frame_valid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
